calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Front-end controller for the 4-bit calculator display path.
- Debounces two push-buttons and steps the user through a fixed entry sequence: operand A, then operand B, then opcode, all from 4 slide switches.
- Issues a start/done handshake to the ALU, then switches the seven-segment driver between operand view (mode=0) and result view (mode=1).
- Drives numA, numB, instruction and mode directly into the seven-segment display block.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized cycles needed to accept a button level. This is 10 ms at 100 MHz.
- ALU_TIMEOUT, 16: maximum cycles spent in S_WAIT before an error is flagged.
- RESULT_HOLD, 500000000: cycles in S_SHOW before auto-clear. Used only with CALC_AUTO_CLEAR_EN.

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  4  switch value used for operand or opcode entry.
- btn_next  in  1  raw asynchronous "enter/advance" button, active-high.
- btn_clr  in  1  raw asynchronous "clear" button, active-high.
- alu_done  in  1  ALU completion, single-cycle pulse.
- numA  out  4  latched operand A.
- numB  out  4  latched operand B.
- instruction  out  4  latched opcode.
- alu_start  out  1  one-cycle start pulse to the ALU.
- mode  out  1  display mode: 0 = operands, 1 = result.
- phase  out  2  entry phase indicator for LEDs: 00 = A, 01 = B, 10 = OP, 11 = WAIT/SHOW.
- error  out  1  sticky ALU-timeout flag.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=S_A.
  - numA, numB, instruction, alu_start, mode, phase and error all =0.
  - Synchronizers, debounce counters and timers cleared.
- Button conditioning (each button):
  - 2-flop synchronizer feeding a debounce counter.
  - The debounced level flips only after DEBOUNCE_CYCLES consecutive cycles in which the synchronized value differs from the current level. Any mismatch-free cycle resets the counter.
  - The rising edge of the debounced level produces a one-cycle pulse: next_p or clr_p.
  - Latency: if raw goes high in cycle N and stays high, the pulse occurs in cycle N+2+DEBOUNCE_CYCLES.
  - Holding a button gives exactly one pulse. Glitches shorter than DEBOUNCE_CYCLES give no pulse.
- FSM states S_A, S_B, S_OP, S_WAIT, S_SHOW. Register updates occur on the clock edge that samples the pulse.
  - S_A: on next_p, numA<=sw; go to S_B.
  - S_B: on next_p, numB<=sw; go to S_OP.
  - S_OP: on next_p, instruction<=sw, alu_start=1 for exactly that one cycle (registered output, high the cycle after the sampling edge), error<=0, timer<=0; go to S_WAIT.
  - S_WAIT:
    - Timer increments each cycle.
    - alu_done=1 goes to S_SHOW.
    - If the timer reaches ALU_TIMEOUT-1 without done: error<=1, go to S_A, operands retained.
    - done in the same cycle as expiry: done wins, no error.
    - next_p is ignored.
  - S_SHOW: mode=1. On next_p, go to S_A with mode=0; operands are retained for display until overwritten.
- clr_p in any state:
  - Go to S_A; numA, numB, instruction, mode and error <=0.
  - Clears alu_start and the timer.
  - clr_p wins over a simultaneous next_p or alu_done.
- alu_done outside S_WAIT is ignored.
- mode is registered and equals 1 exactly while state==S_SHOW.
- phase is a registered decode of state.
- A reset mid-S_WAIT abandons the ALU transaction. The ALU must tolerate a missing handshake.

Optional Feature:
- Macro: CALC_AUTO_CLEAR_EN.
- Defined:
  - S_SHOW runs a hold counter from entry.
  - After RESULT_HOLD cycles with no next_p, behaves as clr_p: go to S_A and zero numA, numB, instruction and mode.
  - next_p before expiry behaves normally and does not clear.
- Undefined: S_SHOW persists indefinitely; no hold counter is synthesized.

Decomposition:
- Package calc_pkg:
  - State enum: S_A=0, S_B=1, S_OP=2, S_WAIT=3, S_SHOW=4.
  - PHASE_* encodings.
  - Operand/opcode width constant DATA_W=4.
- One sub-module: btn_debounce, with parameter DEBOUNCE_CYCLES, ports clk, rst_n, raw, level, press_p. It is instantiated twice.
- Counter widths derive from $clog2 of each parameter.

Test Plan:
- Test 1, full sequence (sim DEBOUNCE_CYCLES=4, ALU_TIMEOUT=16):
  - Stimulus: press next with sw=3, then 5, then 1; alu_done 3 cycles after alu_start.
  - Required: numA=3, numB=5, instruction=1; a single 1-cycle alu_start; mode=1 one cycle after done; phase=11.
- Test 2, bounce rejection:
  - Stimulus: btn_next toggles every 2 cycles for 20 cycles, then stays high for 10 cycles.
  - Required: exactly one next_p, 6 cycles after the final rise; one state advance.
- Test 3, ALU timeout:
  - Stimulus: enter A/B/OP and never assert alu_done.
  - Required: exactly 16 cycles after alu_start, error=1, state S_A, operands unchanged. The next successful start clears error.
- Test 4, clear priority:
  - Stimulus: clr_p and next_p in the same cycle while in S_OP with numA=9.
  - Required: state S_A; numA, numB and instruction =0; no alu_start.
- Test 5, asynchronous reset:
  - Stimulus: assert rst_n=0 mid-S_WAIT, asynchronous to clk.
  - Required: all outputs 0 immediately; after release, a stray alu_done is ignored and state stays S_A.
- Test 6, auto-clear (CALC_AUTO_CLEAR_EN defined, RESULT_HOLD=8):
  - Stimulus: reach S_SHOW and wait.
  - Required: after 8 cycles, mode=0 and all operands 0.
  - Without the macro, mode stays 1 for over 100 cycles.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front-end sequencer.
package calc_pkg;

  localparam int unsigned DATA_W = 4;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_WAIT = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [1:0] PHASE_A   = 2'b00;
  localparam logic [1:0] PHASE_B   = 2'b01;
  localparam logic [1:0] PHASE_OP  = 2'b10;
  localparam logic [1:0] PHASE_RUN = 2'b11;

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      S_A:     return PHASE_A;
      S_B:     return PHASE_B;
      S_OP:    return PHASE_OP;
      default: return PHASE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/calc_sequencer_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_p
);

  localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_q;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= raw;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      // Level flips on the last of DEBOUNCE_CYCLES consecutive mismatching cycles.
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level   = r_level;
  assign press_p = r_level & ~r_level_q;

endmodule

// File: rtl/calc_sequencer.sv
// Entry sequencer for the 4-bit calculator: A, B, opcode, ALU handshake, result view.
// Optional CALC_AUTO_CLEAR_EN: result view clears itself after RESULT_HOLD cycles.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned ALU_TIMEOUT     = 16
`ifdef CALC_AUTO_CLEAR_EN
  ,
  parameter int unsigned RESULT_HOLD     = 500000000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_next,
  input  logic              btn_clr,
  input  logic              alu_done,
  output logic [DATA_W-1:0] numA,
  output logic [DATA_W-1:0] numB,
  output logic [DATA_W-1:0] instruction,
  output logic              alu_start,
  output logic              mode,
  output logic [1:0]        phase,
  output logic              error
);

  localparam int unsigned      TMR_W    = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ALU_TIMEOUT - 1);

  logic w_next_p;
  logic w_clr_p;
  logic w_next_level;
  logic w_clr_level;
  logic w_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (btn_next),
    .level   (w_next_level),
    .press_p (w_next_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (btn_clr),
    .level   (w_clr_level),
    .press_p (w_clr_p)
  );

  assign w_unused = w_next_level ^ w_clr_level;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_numA;
  logic [DATA_W-1:0] w_numA_nxt;
  logic [DATA_W-1:0] r_numB;
  logic [DATA_W-1:0] w_numB_nxt;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] w_instr_nxt;
  logic              r_start;
  logic              w_start_nxt;
  logic              r_mode;
  logic [1:0]        r_phase;
  logic              r_error;
  logic              w_error_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [TMR_W-1:0]  w_timer_nxt;

`ifdef CALC_AUTO_CLEAR_EN
  localparam int unsigned       HOLD_W    = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESULT_HOLD - 1);

  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hold <= '0;
    else        r_hold <= w_hold_nxt;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_numA_nxt  = r_numA;
    w_numB_nxt  = r_numB;
    w_instr_nxt = r_instr;
    w_error_nxt = r_error;
    w_start_nxt = 1'b0;
    w_timer_nxt = r_timer;
`ifdef CALC_AUTO_CLEAR_EN
    w_hold_nxt  = '0;
`endif
    if (w_clr_p) begin
      w_state_nxt = S_A;
      w_numA_nxt  = '0;
      w_numB_nxt  = '0;
      w_instr_nxt = '0;
      w_error_nxt = 1'b0;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        S_A: if (w_next_p) begin
          w_numA_nxt  = sw;
          w_state_nxt = S_B;
        end
        S_B: if (w_next_p) begin
          w_numB_nxt  = sw;
          w_state_nxt = S_OP;
        end
        S_OP: if (w_next_p) begin
          w_instr_nxt = sw;
          w_start_nxt = 1'b1;
          w_error_nxt = 1'b0;
          w_timer_nxt = '0;
          w_state_nxt = S_WAIT;
        end
        // done is tested first so it wins over a coincident expiry
        S_WAIT: begin
          if (alu_done) begin
            w_state_nxt = S_SHOW;
          end else if (r_timer == TMR_LAST) begin
            w_error_nxt = 1'b1;
            w_state_nxt = S_A;
          end else begin
            w_timer_nxt = r_timer + TMR_W'(1);
          end
        end
        S_SHOW: begin
          if (w_next_p) begin
            w_state_nxt = S_A;
`ifdef CALC_AUTO_CLEAR_EN
          end else if (r_hold == HOLD_LAST) begin
            w_state_nxt = S_A;
            w_numA_nxt  = '0;
            w_numB_nxt  = '0;
            w_instr_nxt = '0;
          end else begin
            w_hold_nxt = r_hold + HOLD_W'(1);
`endif
          end
        end
        default: w_state_nxt = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A;
      r_numA  <= '0;
      r_numB  <= '0;
      r_instr <= '0;
      r_start <= 1'b0;
      r_mode  <= 1'b0;
      r_phase <= PHASE_A;
      r_error <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_numA  <= w_numA_nxt;
      r_numB  <= w_numB_nxt;
      r_instr <= w_instr_nxt;
      r_start <= w_start_nxt;
      r_mode  <= (w_state_nxt == S_SHOW);
      r_phase <= phase_of(w_state_nxt);
      r_error <= w_error_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  assign numA        = r_numA;
  assign numB        = r_numB;
  assign instruction = r_instr;
  assign alu_start   = r_start;
  assign mode        = r_mode;
  assign phase       = r_phase;
  assign error       = r_error;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer (DEBOUNCE_CYCLES=4, ALU_TIMEOUT=16).
module tb_calc_sequencer;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [3:0] sw       = 4'd0;
  logic       btn_next = 1'b0;
  logic       btn_clr  = 1'b0;
  logic       alu_done = 1'b0;
  logic [3:0] numA;
  logic [3:0] numB;
  logic [3:0] instruction;
  logic       alu_start;
  logic       mode;
  logic [1:0] phase;
  logic       error;

  int n_checks  = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int next_cnt  = 0;
  int s0;
  int n0;

  always #5 clk = ~clk;

  calc_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .ALU_TIMEOUT     (16)
`ifdef CALC_AUTO_CLEAR_EN
    ,
    .RESULT_HOLD     (8)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .btn_next    (btn_next),
    .btn_clr     (btn_clr),
    .alu_done    (alu_done),
    .numA        (numA),
    .numB        (numB),
    .instruction (instruction),
    .alu_start   (alu_start),
    .mode        (mode),
    .phase       (phase),
    .error       (error)
  );

  always @(negedge clk) begin
    if (alu_start === 1'b1) start_cnt++;
    if (dut.w_next_p === 1'b1) next_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic raise_next(input logic [3:0] v);
    sw       = v;
    btn_next = 1'b1;
    tick(7);
  endtask

  task automatic release_next();
    btn_next = 1'b0;
    tick(10);
  endtask

  task automatic press_next(input logic [3:0] v);
    raise_next(v);
    release_next();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_numA"}, 8'(numA), 8'h0);
    check({tag, "_numB"}, 8'(numB), 8'h0);
    check({tag, "_instr"}, 8'(instruction), 8'h0);
    check({tag, "_start"}, 8'(alu_start), 8'h0);
    check({tag, "_mode"}, 8'(mode), 8'h0);
    check({tag, "_phase"}, 8'(phase), 8'h0);
    check({tag, "_error"}, 8'(error), 8'h0);
  endtask

  initial begin
    // Reset state
    #3;
    check_all_zero("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick(2);

    // Test 1: full sequence
    press_next(4'd3);
    check("t1_numA", 8'(numA), 8'h3);
    check("t1_phaseB", 8'(phase), 8'h1);
    press_next(4'd5);
    check("t1_numB", 8'(numB), 8'h5);
    check("t1_phaseOP", 8'(phase), 8'h2);
    s0 = start_cnt;
    raise_next(4'd1);
    check("t1_start", 8'(alu_start), 8'h1);
    check("t1_instr", 8'(instruction), 8'h1);
    check("t1_phaseRUN", 8'(phase), 8'h3);
    tick(1);
    check("t1_start_fall", 8'(alu_start), 8'h0);
    tick(2);
    alu_done = 1'b1;
    tick(1);
    alu_done = 1'b0;
    check("t1_mode", 8'(mode), 8'h1);
    check("t1_phase_show", 8'(phase), 8'h3);
    check("t1_start_count", 8'(start_cnt - s0), 8'h1);

`ifdef CALC_AUTO_CLEAR_EN
    // Test 6: auto-clear after 8 cycles in S_SHOW
    tick(7);
    check("t6_mode_hold", 8'(mode), 8'h1);
    tick(1);
    check("t6_mode", 8'(mode), 8'h0);
    check("t6_numA", 8'(numA), 8'h0);
    check("t6_numB", 8'(numB), 8'h0);
    check("t6_instr", 8'(instruction), 8'h0);
    check("t6_phase", 8'(phase), 8'h0);
    release_next();
`else
    // Test 6 (macro off): result view persists
    release_next();
    tick(110);
    check("t6_mode_persist", 8'(mode), 8'h1);
    press_next(4'd0);
    check("t1_exit_mode", 8'(mode), 8'h0);
    check("t1_exit_phase", 8'(phase), 8'h0);
    check("t1_keep_numA", 8'(numA), 8'h3);
    check("t1_keep_numB", 8'(numB), 8'h5);
    check("t1_keep_instr", 8'(instruction), 8'h1);
`endif

    // Test 2: bounce rejection
    sw = 4'd7;
    n0 = next_cnt;
    for (int i = 0; i < 20; i++) begin
      btn_next = ((i / 2) % 2 == 0);
      tick(1);
    end
    btn_next = 1'b1;
    tick(5);
    check("t2_no_early_pulse", 8'(next_cnt - n0), 8'h0);
    tick(1);
    check("t2_pulse_at_6", 8'(dut.w_next_p), 8'h1);
    check("t2_phase_before", 8'(phase), 8'h0);
    tick(1);
    check("t2_phase_after", 8'(phase), 8'h1);
    check("t2_numA", 8'(numA), 8'h7);
    tick(3);
    release_next();
    check("t2_pulse_count", 8'(next_cnt - n0), 8'h1);
    check("t2_one_advance", 8'(phase), 8'h1);

    // Test 3: ALU timeout, then done coinciding with expiry
    press_next(4'd2);
    check("t3_numB", 8'(numB), 8'h2);
    raise_next(4'd4);
    check("t3_start", 8'(alu_start), 8'h1);
    tick(15);
    check("t3_err_early", 8'(error), 8'h0);
    check("t3_wait_phase", 8'(phase), 8'h3);
    tick(1);
    check("t3_error", 8'(error), 8'h1);
    check("t3_phaseA", 8'(phase), 8'h0);
    check("t3_keep_numA", 8'(numA), 8'h7);
    check("t3_keep_numB", 8'(numB), 8'h2);
    check("t3_keep_instr", 8'(instruction), 8'h4);
    release_next();
    press_next(4'd1);
    press_next(4'd1);
    check("t3_error_sticky", 8'(error), 8'h1);
    raise_next(4'd2);
    check("t3_error_cleared", 8'(error), 8'h0);
    check("t3_start2", 8'(alu_start), 8'h1);
    tick(15);
    alu_done = 1'b1;
    tick(1);
    alu_done = 1'b0;
    check("t3_done_wins_mode", 8'(mode), 8'h1);
    check("t3_done_wins_err", 8'(error), 8'h0);
    release_next();
`ifndef CALC_AUTO_CLEAR_EN
    press_next(4'd0);
`endif
    check("t3_back_to_A", 8'(phase), 8'h0);

    // Test 4: clear wins over simultaneous next in S_OP
    press_next(4'd9);
    check("t4_numA", 8'(numA), 8'h9);
    press_next(4'd6);
    check("t4_phaseOP", 8'(phase), 8'h2);
    s0       = start_cnt;
    sw       = 4'd5;
    btn_next = 1'b1;
    btn_clr  = 1'b1;
    tick(7);
    check_all_zero("t4");
    btn_next = 1'b0;
    btn_clr  = 1'b0;
    tick(10);
    check("t4_no_start", 8'(start_cnt - s0), 8'h0);
    check("t4_phase_after", 8'(phase), 8'h0);

    // Test 5: asynchronous reset mid-S_WAIT
    press_next(4'd3);
    press_next(4'd4);
    raise_next(4'd8);
    check("t5_start", 8'(alu_start), 8'h1);
    tick(3);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    btn_next = 1'b0;
    tick(3);
    #2 rst_n = 1'b1;
    tick(2);
    alu_done = 1'b1;
    tick(1);
    alu_done = 1'b0;
    tick(1);
    check("t5_stray_phase", 8'(phase), 8'h0);
    check("t5_stray_mode", 8'(mode), 8'h0);
    check("t5_stray_start", 8'(alu_start), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
